// File: rtl/eth_rx_frame_buf.sv
// eth_rx_frame_buf: buffers received Ethernet frames, commits CRC-good ones
// and streams them out with the FCS stripped.
module eth_rx_frame_buf #(
  parameter int pADDR_WIDTH     = 11,
  parameter int pLEN_DEPTH_LOG2 = 3,
  parameter int pMIN_BYTES      = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rx_Active,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Byte,
  input  logic        Crc_Valid,
  output logic [7:0]  M_Tdata,
  output logic        M_Tvalid,
  output logic        M_Tlast,
  input  logic        M_Tready,
  output logic        Frame_Drop,
  output logic        Overflow,
  output logic [15:0] Frame_Cnt
);
  typedef logic [pADDR_WIDTH:0] ptr_t;
  typedef logic [pLEN_DEPTH_LOG2:0] lptr_t;
  typedef enum logic [1:0] {IDLE, RECV, CHECK, DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM} rd_state_t;
  logic [7:0] r_mem [2**pADDR_WIDTH];
  ptr_t r_len_mem [2**pLEN_DEPTH_LOG2];
  wr_state_t r_wr_st, w_wr_nxt;
  rd_state_t r_rd_st, w_rd_nxt;
  ptr_t r_wr_ptr, r_cmt_ptr, r_start_ptr, r_rd_ptr, r_cnt, r_rem;
  lptr_t r_lf_wr, r_lf_rd;
  logic r_rx_d, r_crc, r_drop, r_ovf;
  logic [7:0] r_tdata;
  logic [15:0] r_frame_cnt;
  logic w_full, w_lf_full, w_lf_empty, w_ok;
  logic w_start, w_we, w_ovf, w_drop, w_commit, w_pop, w_load, w_adv;
  // Fullness is measured against the read pointer so uncommitted bytes count too
  assign w_full     = (r_wr_ptr - r_rd_ptr) == ptr_t'(2**pADDR_WIDTH);
  assign w_lf_full  = (r_lf_wr - r_lf_rd) == lptr_t'(2**pLEN_DEPTH_LOG2);
  assign w_lf_empty = r_lf_wr == r_lf_rd;
  assign w_ok       = r_crc && r_cnt >= ptr_t'(pMIN_BYTES) && !w_lf_full;
  always_comb begin
    w_wr_nxt = r_wr_st;
    w_start  = 1'b0;
    w_we     = 1'b0;
    w_ovf    = 1'b0;
    w_drop   = 1'b0;
    w_commit = 1'b0;
    case (r_wr_st)
      IDLE: begin
        w_start  = Rx_Active && !r_rx_d;
        w_wr_nxt = w_start ? RECV : IDLE;
      end
      RECV: begin
        w_ovf    = Rx_Active && Byte_Rdy && w_full;
        w_we     = Rx_Active && Byte_Rdy && !w_full;
        w_wr_nxt = !Rx_Active ? CHECK : w_ovf ? DROP : RECV;
      end
      CHECK: begin
        w_commit = w_ok;
        w_drop   = !w_ok;
        w_wr_nxt = IDLE;
      end
      DROP: begin
        w_drop   = !Rx_Active;
        w_wr_nxt = Rx_Active ? DROP : IDLE;
      end
      default: w_wr_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      r_wr_st     <= IDLE;
      r_rx_d      <= 1'b0;
      r_crc       <= 1'b0;
      r_drop      <= 1'b0;
      r_ovf       <= 1'b0;
      r_wr_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_start_ptr <= '0;
      r_cnt       <= '0;
      r_lf_wr     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_wr_st <= w_wr_nxt;
      r_rx_d  <= Rx_Active;
      r_drop  <= w_drop;
      r_ovf   <= w_ovf;
      if (r_wr_st == RECV && !Rx_Active)
        r_crc <= Crc_Valid;
      if (w_start) begin
        r_start_ptr <= r_cmt_ptr;
        r_wr_ptr    <= r_cmt_ptr;
        r_cnt       <= '0;
      end
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_cmt_ptr   <= r_wr_ptr - ptr_t'(4);
        r_wr_ptr    <= r_wr_ptr - ptr_t'(4);
        r_lf_wr     <= r_lf_wr + 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_drop)
        r_wr_ptr <= r_start_ptr;
    end
  always_ff @(posedge Clk) begin
    if (w_we)
      r_mem[r_wr_ptr[pADDR_WIDTH-1:0]] <= Byte;
    if (w_commit)
      r_len_mem[r_lf_wr[pLEN_DEPTH_LOG2-1:0]] <= r_cnt - ptr_t'(4);
  end
  always_comb begin
    w_rd_nxt = r_rd_st;
    w_pop    = 1'b0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    case (r_rd_st)
      RD_IDLE: begin
        w_pop    = !w_lf_empty;
        w_rd_nxt = w_pop ? RD_LOAD : RD_IDLE;
      end
      RD_LOAD: begin
        w_load   = 1'b1;
        w_rd_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        w_adv    = M_Tready && r_rem != ptr_t'(1);
        w_load   = w_adv;
        w_rd_nxt = M_Tready && !w_adv ? RD_IDLE : RD_STREAM;
      end
      default: w_rd_nxt = RD_IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      r_rd_st  <= RD_IDLE;
      r_rd_ptr <= '0;
      r_lf_rd  <= '0;
      r_rem    <= '0;
      r_tdata  <= '0;
    end else begin
      r_rd_st <= w_rd_nxt;
      if (w_pop) begin
        r_rem   <= r_len_mem[r_lf_rd[pLEN_DEPTH_LOG2-1:0]];
        r_lf_rd <= r_lf_rd + 1'b1;
      end
      if (w_adv)
        r_rem <= r_rem - 1'b1;
      if (w_load) begin
        r_tdata  <= r_mem[r_rd_ptr[pADDR_WIDTH-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  assign M_Tdata    = r_tdata;
  assign M_Tvalid   = r_rd_st == RD_STREAM;
  assign M_Tlast    = M_Tvalid && r_rem == ptr_t'(1);
  assign Frame_Drop = r_drop;
  assign Overflow   = r_ovf;
  assign Frame_Cnt  = r_frame_cnt;
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// tb_eth_rx_frame_buf: directed frame vectors plus hand-written overflow,
// back-pressure and mid-frame reset sequences against a 128-byte buffer.
module tb_eth_rx_frame_buf;
  typedef struct {
    int       len;
    bit       crc;
    bit       good;
    int       seed;
  } vec_t;
  logic clk, rst, rx, br, crc, tready, tvalid, tlast, drop, ovf;
  logic [7:0] b, tdata;
  logic [15:0] fcnt;
  int checks = 0, errors = 0, exp_cnt = 0, n_drop = 0, n_ovf = 0, n_stall = 0;
  logic [7:0] q_data[$];
  logic q_last[$];
  logic st_prev = 1'b0, st_last = 1'b0, tog = 1'b0;
  logic [7:0] st_data = 8'h00;
  vec_t vecs[7];
  eth_rx_frame_buf #(.pADDR_WIDTH(7)) dut (
    .Clk(clk), .Rst(rst), .Rx_Active(rx), .Byte_Rdy(br), .Byte(b),
    .Crc_Valid(crc), .M_Tdata(tdata), .M_Tvalid(tvalid), .M_Tlast(tlast),
    .M_Tready(tready), .Frame_Drop(drop), .Overflow(ovf), .Frame_Cnt(fcnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (st_prev) begin
      check("stall_valid", 32'(tvalid), 1);
      check("stall_data", 32'(tdata), 32'(st_data));
      check("stall_last", 32'(tlast), 32'(st_last));
    end
    st_prev = tvalid === 1'b1 && tready === 1'b0 && rst === 1'b0;
    if (st_prev) n_stall++;
    st_data = tdata;
    st_last = tlast;
    if (tvalid === 1'b1 && tready === 1'b1) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
    end
    if (drop === 1'b1) n_drop++;
    if (ovf === 1'b1) n_ovf++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tog) tready = ~tready;
  endtask
  task automatic send_frame(input int len, input bit c, input int seed, input bit gap);
    rx = 1'b1;
    cyc();
    for (int i = 0; i < len; i++) begin
      br = 1'b1;
      b = 8'(seed + i);
      cyc();
      if (gap) begin
        br = 1'b0;
        cyc();
      end
    end
    br = 1'b0;
    rx = 1'b0;
    crc = c;
    cyc();
    crc = 1'b0;
    cyc();
  endtask
  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) cyc();
  endtask
  task automatic check_frame(input string nm, input int start, input int n, input int seed);
    int bad_d = 0, bad_l = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i >= q_data.size()) begin
        bad_d++;
        bad_l++;
      end else begin
        if (q_data[start+i] !== 8'(seed + i)) bad_d++;
        if (q_last[start+i] !== (i == n - 1)) bad_l++;
      end
    end
    check({nm, "_data"}, bad_d, 0);
    check({nm, "_last"}, bad_l, 0);
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int d0 = n_drop, q0 = q_data.size();
    send_frame(v.len, v.crc, v.seed, 1'b0);
    if (v.good) begin
      exp_cnt++;
      wait_bytes(q0 + v.len - 4, 2000);
    end else repeat (20) cyc();
    repeat (3) cyc();
    check({nm, "_drop"}, n_drop - d0, v.good ? 0 : 1);
    check({nm, "_cnt"}, 32'(fcnt), exp_cnt);
    check({nm, "_bytes"}, q_data.size() - q0, v.good ? v.len - 4 : 0);
    if (v.good) check_frame(nm, q0, v.len - 4, v.seed);
  endtask
  initial begin
    int q0, d0, ovf_at;
    rst = 1'b1; rx = 1'b0; br = 1'b0; b = 8'h00; crc = 1'b0; tready = 1'b0;
    vecs[0] = '{len: 64,  crc: 1'b1, good: 1'b1, seed: 8'h10};
    vecs[1] = '{len: 64,  crc: 1'b0, good: 1'b0, seed: 8'h20};
    vecs[2] = '{len: 70,  crc: 1'b1, good: 1'b1, seed: 8'h30};
    vecs[3] = '{len: 40,  crc: 1'b1, good: 1'b0, seed: 8'h40};
    vecs[4] = '{len: 63,  crc: 1'b1, good: 1'b0, seed: 8'h50};
    vecs[5] = '{len: 65,  crc: 1'b1, good: 1'b1, seed: 8'h60};
    vecs[6] = '{len: 128, crc: 1'b1, good: 1'b1, seed: 8'h70};
    repeat (3) cyc();
    check("rst_valid", 32'(tvalid), 0);
    check("rst_last", 32'(tlast), 0);
    check("rst_data", 32'(tdata), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_cnt", 32'(fcnt), 0);
    rst = 1'b0;
    tready = 1'b1;
    cyc();
    foreach (vecs[k]) run_vec($sformatf("vec%0d", k), vecs[k]);
    // Overflow: 200 bytes into a 128-byte buffer with the reader stalled
    tready = 1'b0;
    d0 = n_drop;
    q0 = q_data.size();
    ovf_at = -1;
    rx = 1'b1;
    cyc();
    for (int i = 0; i < 200; i++) begin
      br = 1'b1;
      b = 8'(i);
      cyc();
      if (ovf === 1'b1 && ovf_at < 0) ovf_at = i;
    end
    br = 1'b0;
    rx = 1'b0;
    crc = 1'b1;
    cyc();
    crc = 1'b0;
    check("ovf_byte", ovf_at, 128);
    check("ovf_drop_now", 32'(drop), 1);
    tready = 1'b1;
    repeat (20) cyc();
    check("ovf_drop_once", n_drop - d0, 1);
    check("ovf_no_out", q_data.size() - q0, 0);
    check("ovf_cnt", 32'(fcnt), exp_cnt);
    run_vec("after_ovf", '{len: 128, crc: 1'b1, good: 1'b1, seed: 8'h5A});
    // Back-pressure: ready toggles across three back-to-back 100-byte frames
    q0 = q_data.size();
    n_stall = 0;
    tog = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(100, 1'b1, 8'h40 * (f + 1), 1'b1);
    wait_bytes(q0 + 288, 3000);
    tog = 1'b0;
    tready = 1'b1;
    exp_cnt += 3;
    check("tog_bytes", q_data.size() - q0, 288);
    for (int f = 0; f < 3; f++) check_frame($sformatf("tog%0d", f), q0 + 96 * f, 96, 8'h40 * (f + 1));
    check("tog_cnt", 32'(fcnt), exp_cnt);
    check("tog_stalled", n_stall > 0, 1);
    // Reset asserted on byte 30 of a frame
    d0 = n_drop;
    rx = 1'b1;
    cyc();
    for (int i = 0; i < 30; i++) begin
      br = 1'b1;
      b = 8'(i + 1);
      cyc();
    end
    rst = 1'b1;
    rx = 1'b0;
    br = 1'b0;
    cyc();
    check("mid_rst_valid", 32'(tvalid), 0);
    check("mid_rst_last", 32'(tlast), 0);
    check("mid_rst_data", 32'(tdata), 0);
    check("mid_rst_drop", 32'(drop), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_cnt", 32'(fcnt), 0);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (10) cyc();
    check("mid_rst_nodrop", n_drop - d0, 0);
    run_vec("after_rst", '{len: 80, crc: 1'b1, good: 1'b1, seed: 8'h33});
    check("ovf_total", n_ovf, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
